// File: rtl/countdown_timer.sv
// BCD H:MM:SS countdown timer with done pulse and sticky expired flag.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last valid preset at zero.
module countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned PRESC_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] ld_s0,
  input  logic [3:0] ld_s1,
  input  logic [3:0] ld_m0,
  input  logic [3:0] ld_m1,
  input  logic [3:0] ld_h,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic [3:0] h,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  localparam logic [PRESC_W-1:0] PRESC_MAX =
    PRESC_W'(TICKS_PER_SEC - 1);

  logic [3:0] s0_q, s0_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] m0_q, m0_d;
  logic [3:0] m1_q, m1_d;
  logic [3:0] h_q, h_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic expired_q, expired_d;
  logic done_q, done_d;
  logic load_err_q, load_err_d;
  logic ld_ok;
  logic nonzero;
  logic at_one;
  logic tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [19:0] preset_q, preset_d;
`endif

  always_comb begin
    ld_ok = (ld_s0 <= 4'd9) && (ld_s1 <= 4'd5) &&
            (ld_m0 <= 4'd9) && (ld_m1 <= 4'd5) &&
            (ld_h <= 4'd9);
    nonzero = |{h_q, m1_q, m0_q, s1_q, s0_q};
    at_one  = ({h_q, m1_q, m0_q, s1_q} == 16'd0) &&
              (s0_q == 4'd1);
    running = enable & ~expired_q & nonzero;
    tick    = running && (presc_q == PRESC_MAX);
  end

  always_comb begin
    s0_d       = s0_q;
    s1_d       = s1_q;
    m0_d       = m0_q;
    m1_d       = m1_q;
    h_d        = h_q;
    presc_d    = presc_q;
    expired_d  = expired_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    preset_d   = preset_q;
`endif
    if (load && ld_ok) begin
      s0_d      = ld_s0;
      s1_d      = ld_s1;
      m0_d      = ld_m0;
      m1_d      = ld_m1;
      h_d       = ld_h;
      presc_d   = '0;
      expired_d = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      preset_d  = {ld_h, ld_m1, ld_m0, ld_s1, ld_s0};
`endif
    end else begin
      // A rejected load leaves the count running untouched
      load_err_d = load;
      if (running)
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      if (tick && at_one) begin
        done_d = 1'b0 | 1'b1;
        s0_d   = 4'd0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (preset_q != 20'd0)
          {h_d, m1_d, m0_d, s1_d, s0_d} = preset_q;
        else
          expired_d = 1'b1;
`else
        expired_d = 1'b1;
`endif
      end else if (tick) begin
        s0_d = (s0_q == 4'd0) ? 4'd9 : s0_q - 4'd1;
        if (s0_q == 4'd0) begin
          s1_d = (s1_q == 4'd0) ? 4'd5 : s1_q - 4'd1;
          if (s1_q == 4'd0) begin
            m0_d = (m0_q == 4'd0) ? 4'd9 : m0_q - 4'd1;
            if (m0_q == 4'd0) begin
              m1_d = (m1_q == 4'd0) ? 4'd5 : m1_q - 4'd1;
              if (m1_q == 4'd0)
                h_d = h_q - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q       <= '0;
      s1_q       <= '0;
      m0_q       <= '0;
      m1_q       <= '0;
      h_q        <= '0;
      presc_q    <= '0;
      expired_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      preset_q   <= '0;
`endif
    end else begin
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      m0_q       <= m0_d;
      m1_q       <= m1_d;
      h_q        <= h_d;
      presc_q    <= presc_d;
      expired_q  <= expired_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      preset_q   <= preset_d;
`endif
    end
  end

  assign s0       = s0_q;
  assign s1       = s1_q;
  assign m0       = m0_q;
  assign m1       = m1_q;
  assign h        = h_q;
  assign done     = done_q;
  assign expired  = expired_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer at TICKS_PER_SEC=2.
// Observation word: {h,m1,m0,s1,s0,done,expired,running,load_err}.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic [3:0] ld_s0 = '0, ld_s1 = '0, ld_m0 = '0;
  logic [3:0] ld_m1 = '0, ld_h = '0;
  logic [3:0] s0, s1, m0, m1, h;
  logic running, done, expired, load_err;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [23:0] v;
  } exp_t;

  exp_t sb[$];

  countdown_timer #(
    .TICKS_PER_SEC(2),
    .PRESC_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load(load),
    .ld_s0(ld_s0),
    .ld_s1(ld_s1),
    .ld_m0(ld_m0),
    .ld_m1(ld_m1),
    .ld_h(ld_h),
    .s0(s0),
    .s1(s1),
    .m0(m0),
    .m1(m1),
    .h(h),
    .running(running),
    .done(done),
    .expired(expired),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [23:0] act,
                       input logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_ld(input logic [19:0] d);
    {ld_h, ld_m1, ld_m0, ld_s1, ld_s0} = d;
  endtask

  task automatic cyc(input string tag,
                     input logic [19:0] d,
                     input logic dn, input logic ex,
                     input logic rn, input logic le);
    exp_t e;
    logic [23:0] obs;
    e.tag = tag;
    e.v = {d, dn, ex, rn, le};
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs = {h, m1, m0, s1, s0, done, expired, running, load_err};
    e = sb.pop_front();
    check(e.tag, obs, e.v);
  endtask

  initial begin
    cyc("rst", 20'h00000, 0, 0, 0, 0);
    reset = 1'b0;

    load = 1'b1; set_ld(20'h00003); enable = 1'b1;
    cyc("t1_ld", 20'h00003, 0, 0, 1, 0);
    load = 1'b0;
    cyc("t1_c1", 20'h00003, 0, 0, 1, 0);
    cyc("t1_c2", 20'h00002, 0, 0, 1, 0);
    cyc("t1_c3", 20'h00002, 0, 0, 1, 0);
    cyc("t1_c4", 20'h00001, 0, 0, 1, 0);
    cyc("t1_c5", 20'h00001, 0, 0, 1, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    cyc("t1_reload", 20'h00003, 1, 0, 1, 0);
`else
    cyc("t1_zero", 20'h00000, 1, 1, 0, 0);
    cyc("t1_hold1", 20'h00000, 0, 1, 0, 0);
    cyc("t1_hold2", 20'h00000, 0, 1, 0, 0);
    cyc("t1_hold3", 20'h00000, 0, 1, 0, 0);
`endif

    load = 1'b1; set_ld(20'h00000);
    cyc("ld_zero", 20'h00000, 0, 0, 0, 0);
    load = 1'b0;
    cyc("idle", 20'h00000, 0, 0, 0, 0);

    load = 1'b1; set_ld(20'hA0000);
    cyc("bad_h", 20'h00000, 0, 0, 0, 1);
    load = 1'b0;
    cyc("bad_h_clr", 20'h00000, 0, 0, 0, 0);

    enable = 1'b0; load = 1'b1; set_ld(20'h95959);
    cyc("ld_max", 20'h95959, 0, 0, 0, 0);

    enable = 1'b1; set_ld(20'h10000);
    cyc("t2_ld", 20'h10000, 0, 0, 1, 0);
    load = 1'b0;
    cyc("t2_c1", 20'h10000, 0, 0, 1, 0);
    cyc("t2_chain", 20'h05959, 0, 0, 1, 0);
    cyc("t2_c3", 20'h05959, 0, 0, 1, 0);
    cyc("t2_next", 20'h05958, 0, 0, 1, 0);

    load = 1'b1; set_ld(20'h00005);
    cyc("t3_ld", 20'h00005, 0, 0, 1, 0);
    load = 1'b0;
    cyc("t3_c1", 20'h00005, 0, 0, 1, 0);
    load = 1'b1; set_ld(20'h00065);
    cyc("t3_err", 20'h00004, 0, 0, 1, 1);
    load = 1'b0;
    cyc("t3_c3", 20'h00004, 0, 0, 1, 0);
    cyc("t3_cont", 20'h00003, 0, 0, 1, 0);

    load = 1'b1; set_ld(20'h00005);
    cyc("t4_ld", 20'h00005, 0, 0, 1, 0);
    load = 1'b0;
    cyc("t4_half", 20'h00005, 0, 0, 1, 0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++)
      cyc("t4_frz", 20'h00005, 0, 0, 0, 0);
    enable = 1'b1;
    cyc("t4_resume", 20'h00004, 0, 0, 1, 0);

    load = 1'b1; set_ld(20'h00002);
    cyc("t5_ld", 20'h00002, 0, 0, 1, 0);
    load = 1'b0;
    cyc("t5_c1", 20'h00002, 0, 0, 1, 0);
    load = 1'b1; set_ld(20'h00009);
    cyc("t5_race", 20'h00009, 0, 0, 1, 0);
    load = 1'b0;
    cyc("t5_c3", 20'h00009, 0, 0, 1, 0);
    cyc("t5_next", 20'h00008, 0, 0, 1, 0);
    reset = 1'b1; load = 1'b1; set_ld(20'h00007);
    cyc("t5_rst", 20'h00000, 0, 0, 0, 0);
    reset = 1'b0; load = 1'b0;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    load = 1'b1; set_ld(20'h00002);
    cyc("ar_ld", 20'h00002, 0, 0, 1, 0);
    load = 1'b0;
    cyc("ar_c1", 20'h00002, 0, 0, 1, 0);
    cyc("ar_c2", 20'h00001, 0, 0, 1, 0);
    cyc("ar_c3", 20'h00001, 0, 0, 1, 0);
    cyc("ar_wrap1", 20'h00002, 1, 0, 1, 0);
    cyc("ar_c5", 20'h00002, 0, 0, 1, 0);
    cyc("ar_c6", 20'h00001, 0, 0, 1, 0);
    cyc("ar_c7", 20'h00001, 0, 0, 1, 0);
    cyc("ar_wrap2", 20'h00002, 1, 0, 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Count-down counterpart of the stopwatch: loads a preset H:MM:SS value as BCD digits and decrements it once per second to zero.
- Presents the same digit outputs as the stopwatch (s0, s1, m0, m1, h), so the VGA digit renderer can display either source unchanged.
- Raises a done pulse and a sticky expired flag at zero.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per one-second decrement (must be >= 1; tests use 2).
- PRESC_W, 26, prescaler counter width (must satisfy 2^PRESC_W >= TICKS_PER_SEC).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = count, 0 = freeze (prescaler and digits hold)
- load  in  1  1-cycle strobe; capture ld_* digits
- ld_s0  in  4  preset seconds units (0-9)
- ld_s1  in  4  preset seconds tens (0-5)
- ld_m0  in  4  preset minutes units (0-9)
- ld_m1  in  4  preset minutes tens (0-5)
- ld_h  in  4  preset hours (0-9)
- s0, s1, m0, m1, h  out  4 each  current BCD digits, registered
- running  out  1  enable & ~expired & (value != 0), combinational from registers
- done  out  1  1-cycle pulse when count reaches zero by decrement
- expired  out  1  sticky: set with done, cleared by load or reset
- load_err  out  1  1-cycle pulse: load rejected due to out-of-range digit

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset state:
  - All digits 0, prescaler 0, expired 0, done 0, load_err 0.
  - The zero state after reset is idle, not expired.
- Priority: reset > load > tick decrement.
- Load (load=1):
  - Valid load requires ld_s0, ld_m0, ld_h <= 9 and ld_s1, ld_m1 <= 5.
  - Valid: digits take ld_* on the next edge; prescaler cleared to 0; expired cleared.
  - Invalid: all state unchanged; load_err=1 for exactly one cycle.
  - Loading 0:00:00 gives the idle zero state: expired=0, no done.
- Prescaler:
  - Increments only when running=1.
  - On reaching TICKS_PER_SEC-1 it wraps to 0 and generates an internal tick in that cycle.
  - First decrement therefore occurs TICKS_PER_SEC running cycles after a load.
  - Holds while enable=0.
- Decrement on tick (BCD borrow chain):
  - s0: 0->9 with borrow, else -1.
  - s1: 0->5 with borrow, else -1; only on borrow from s0.
  - m0: 0->9 with borrow, else -1; only on borrow from s1.
  - m1: 0->5 with borrow, else -1; only on borrow from m0.
  - h: -1; only on borrow from m1.
  - h never underflows, because ticks occur only with a nonzero value.
- Zero reached:
  - When a tick takes the value from 0:00:01 to 0:00:00, done=1 and expired=1 on the same edge that the digits become zero.
  - done drops after 1 cycle; expired holds.
  - While expired or value zero: running=0, prescaler frozen, no further ticks.
- enable fall mid-second: the prescaler keeps its partial count and resumes from it.
- Load coincident with tick: load wins; the tick is discarded; prescaler cleared.
- Reset mid-count: on the next edge, all outputs and state return to reset values regardless of load/enable.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - An internal 20-bit preset register captures every valid load; it resets to 0.
  - On the tick that would reach zero: digits load the preset instead of 0:00:00, done pulses, expired stays 0, prescaler restarts from 0.
  - If the preset is 0:00:00, behaviour is as if undefined.
- Undefined: no preset register; the count stops at zero with expired=1.

Test Plan (TICKS_PER_SEC=2):
- Reset then load 0:00:03, enable=1 -> digits 0:00:02 after 2 cycles, 0:00:01 after 4, 0:00:00 after 6 with done=1 for 1 cycle; expired=1 and running=0 thereafter; digits hold at 0.
- Load 1:00:00, one tick -> 0:59:59, full borrow chain; next tick -> 0:59:58.
- Load with ld_s1=6 (others valid) while counting 0:00:05 -> load_err pulse; digits and prescaler continue unchanged.
- Load 0:00:05, enable=1 for 1 cycle, enable=0 for 10 cycles, enable=1 -> value stays 0:00:05 while frozen; first decrement to 0:00:04 exactly 1 running cycle after re-enable.
- Load 0:00:02, assert load 0:00:09 in the same cycle as a tick -> digits 0:00:09, not 0:00:08; next tick 2 cycles later -> 0:00:08. Then reset mid-count -> all digits 0, expired 0 next edge.
- With COUNTDOWN_AUTO_RELOAD_EN: load 0:00:02 -> sequence 2,1,2,1,... with done pulsing on each wrap; expired never 1.
